turbo_stream_receiver: RTL
==========================

Name: turbo_stream_receiver

Overview:
Receive end of the turbo encoder's serial output interface. Consumes the two-wire (out0/out1 + valid) beat stream produced by the encoder's output stage and demultiplexes it back into systematic x, parity z and interleaved parity z' per trellis step. Re-encodes x with a local RSC to check every z bit and the rsc_1 termination tail. Flags per-block parity errors. Sits between the encoder and the downstream decoder or scoreboard, clocked on the fast output clock.

Parameters:
K, 40, information bits per block (trellis steps before termination)
TAIL, 3, termination steps per constituent encoder (equals RSC memory)
ERRW, 8, width of the saturating parity-error counter

Ports:
clk  input  1  fast clock; all logic on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
in0  input  1  serial lane 0 (encoder out0)
in1  input  1  serial lane 1 (encoder out1)
valid_in  input  1  beat qualifier (encoder valid)
x_out  output  1  recovered systematic bit
z_out  output  1  received parity z
zp_out  output  1  received interleaved parity z'
data_valid  output  1  one-cycle strobe, x_out/z_out/zp_out valid
block_done  output  1  one-cycle pulse after last tail beat
parity_err  output  1  sticky for current block; set on any mismatch
err_count  output  ERRW  mismatches in current block, saturating at all-ones
busy  output  1  high from first beat of a block until block_done

Behaviour:
- Interface is fixed: one clk, reset synchronous active-high, named clk and reset.
- Beat format: each trellis step is two valid beats.
  - Data phase, beat A: in0 = x_k, in1 = z_k.
  - Data phase, beat B: in0 = z'_k, in1 = x'_k. x'_k is ignored.
  - Tail phase: TAIL steps. Beat A: in0 = x_tail, in1 = z_tail (rsc_1). Beat B: in0 = x'_tail, in1 = z'_tail (rsc_2). rsc_2 tail is not checked.
- FSM states: IDLE, DATA_A, DATA_B, TAIL_A, TAIL_B, DONE.
  - IDLE -> DATA_B on a valid beat. That beat is captured as beat A of step 0, and busy is set.
  - DATA_A <-> DATA_B alternate on each valid beat. The step counter increments on each beat B.
  - After beat B of step K-1, go to TAIL_A.
  - TAIL_A <-> TAIL_B alternate on each valid beat.
  - After beat B of tail step TAIL-1, go to DONE.
  - DONE -> IDLE in the next cycle, unconditionally.
- Stall: when valid_in is low, there is no state, counter or re-encoder change. Gaps of any length between beats are legal.
- Re-encoder state s[2:0] (s0 = D1), reset to 000 at block start.
  - Data step: f = x ^ s1 ^ s2; z_exp = f ^ s0 ^ s2.
  - Tail step: x_exp = s1 ^ s2, f = 0, z_exp = s0 ^ s2.
  - Update on every beat B: s0 <= f, s1 <= s0, s2 <= s1.
- Mismatch events: counted once per step, at beat B.
  - Data step: z != z_exp is one event.
  - Tail step: x != x_exp or z != z_exp is one event.
  - Non-zero s after the final tail step adds one event.
- Latency: x_out, z_out, zp_out and data_valid are registered. data_valid asserts in the cycle after the beat B of each data step. No data_valid during the tail.
- block_done pulses in the DONE cycle. parity_err and err_count hold their values through DONE. They clear on the first beat A of the next block.
- Reset values: all outputs 0, err_count 0, FSM IDLE, s = 000.
- Reset mid-block aborts the block with no block_done. Reset has priority over a simultaneous valid_in.
- err_count saturates at 2^ERRW-1. parity_err remains 1 at saturation.
- A valid_in beat in the DONE cycle is dropped. The upstream encoder never issues one.

Decomposition:
- Shared package turbo_pkg:
  - constants K_DEFAULT = 40 and TAIL_LEN = 3
  - generator taps G_FB = 3'b110 (D2, D3) and G_FF = 3'b101 (D1, D3)
  - FSM state enum rx_state_t
- One sub-module rsc_reencoder: 3-bit state, data/tail mode, step-enable input.
  - Outputs: z_exp, x_exp, state_zero.

Test Plan:
1. All-zero block, K=40, contiguous valid: 86 beats of zeros -> 40 data_valid strobes with x = z = zp = 0; block_done 1 cycle after beat 86; parity_err = 0, err_count = 0.
2. Impulse x_0 = 1, other x = 0, correctly encoded z (z_0..z_3 = 1,1,1,1) and matching tail -> x_out = 1 only on the first strobe; err_count = 0.
3. Same as scenario 2 with z_2 inverted -> parity_err = 1, err_count = 1 at block_done; x_out stream unchanged.
4. Scenario 1 stimulus with valid_in low for 5 cycles after every beat -> identical outputs and counts; busy stays high throughout.
5. Reset asserted at step 20 while valid_in is high -> next cycle: outputs 0, busy = 0, no block_done; a following clean block completes with err_count = 0.
6. Block with every z inverted and ERRW = 4 -> err_count saturates at 15; parity_err = 1; a following clean block reports err_count = 0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared constants, generator taps and FSM state type for the turbo stream receiver.
package turbo_pkg;

    localparam int K_DEFAULT = 40;
    localparam int TAIL_LEN  = 3;

    // Generator taps over the shift register {D3, D2, D1}
    localparam logic [2:0] G_FB = 3'b110;
    localparam logic [2:0] G_FF = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        DATA_A,
        DATA_B,
        TAIL_A,
        TAIL_B,
        DONE
    } rx_state_t;

endpackage

// File: rtl/turbo_stream_receiver_reencoder.sv
// Local RSC re-encoder: predicts the parity (and tail systematic) bit for the
// current trellis step from the received systematic bit, and advances one step
// per enable. state_zero reports whether the register will be zero after the
// pending step, so a termination check can be made in the same cycle.
module rsc_reencoder
    import turbo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic step_en,
    input  logic tail_mode,
    input  logic x_in,
    output logic z_exp,
    output logic x_exp,
    output logic state_zero
);

    logic [2:0] s;
    logic [2:0] s_next;
    logic       fb;
    logic       ff;
    logic       f;

    // Feedback/feed-forward taps; in tail mode the input cancels the feedback
    always_comb begin
        fb         = ^(s & G_FB);
        ff         = ^(s & G_FF);
        x_exp      = fb;
        f          = tail_mode ? 1'b0 : (x_in ^ fb);
        z_exp      = f ^ ff;
        s_next     = {s[1], s[0], f};
        state_zero = (s_next == 3'b000);
    end

    // Shift register: cleared at block start, advanced once per trellis step
    always_ff @(posedge clk) begin
        if (reset) begin
            s <= 3'b000;
        end else if (clear) begin
            s <= 3'b000;
        end else if (step_en) begin
            s <= s_next;
        end
    end

endmodule

// File: rtl/turbo_stream_receiver.sv
// Receive side of the turbo encoder's two-lane serial output. Demultiplexes
// beats back into x, z and z' per step, re-encodes x to check z and the rsc_1
// tail, and reports per-block parity errors.
module turbo_stream_receiver
    import turbo_pkg::*;
#(
    parameter int K    = K_DEFAULT,
    parameter int TAIL = TAIL_LEN,
    parameter int ERRW = 8
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in0,
    input  logic            in1,
    input  logic            valid_in,
    output logic            x_out,
    output logic            z_out,
    output logic            zp_out,
    output logic            data_valid,
    output logic            block_done,
    output logic            parity_err,
    output logic [ERRW-1:0] err_count,
    output logic            busy
);

    localparam int CW = $clog2(K + 1);
    localparam int EW = ERRW + 1;

    rx_state_t     state;
    rx_state_t     next_state;
    logic [CW-1:0] step_cnt;
    logic          x_cap;
    logic          z_cap;
    logic          capture;
    logic          start;
    logic          step_en;
    logic          tail_mode;
    logic          data_step;
    logic          data_last;
    logic          last_tail;
    logic          z_exp;
    logic          x_exp;
    logic          state_zero;
    logic          step_mismatch;
    logic [1:0]    err_inc;
    logic [EW-1:0] err_sum;

    rsc_reencoder u_reencoder (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .step_en    (step_en),
        .tail_mode  (tail_mode),
        .x_in       (x_cap),
        .z_exp      (z_exp),
        .x_exp      (x_exp),
        .state_zero (state_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-beat control; nothing moves while valid_in is low
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        start      = 1'b0;
        step_en    = 1'b0;
        tail_mode  = 1'b0;
        data_step  = 1'b0;
        data_last  = 1'b0;
        last_tail  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    capture    = 1'b1;
                    start      = 1'b1;
                    next_state = DATA_B;
                end
            end
            DATA_A: begin
                if (valid_in) begin
                    capture    = 1'b1;
                    next_state = DATA_B;
                end
            end
            DATA_B: begin
                if (valid_in) begin
                    step_en   = 1'b1;
                    data_step = 1'b1;
                    if (step_cnt == CW'(K - 1)) begin
                        data_last  = 1'b1;
                        next_state = TAIL_A;
                    end else begin
                        next_state = DATA_A;
                    end
                end
            end
            TAIL_A: begin
                tail_mode = 1'b1;
                if (valid_in) begin
                    capture    = 1'b1;
                    next_state = TAIL_B;
                end
            end
            TAIL_B: begin
                tail_mode = 1'b1;
                if (valid_in) begin
                    step_en = 1'b1;
                    if (step_cnt == CW'(TAIL - 1)) begin
                        last_tail  = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = TAIL_A;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Mismatch events for this step, plus the termination check on the last tail step
    always_comb begin
        step_mismatch = 1'b0;
        if (step_en) begin
            step_mismatch = tail_mode ? ((x_cap != x_exp) || (z_cap != z_exp))
                                      : (z_cap != z_exp);
        end
        err_inc = {1'b0, step_mismatch} + {1'b0, last_tail & ~state_zero};
        err_sum = {1'b0, err_count} + EW'(err_inc);
    end

    // Step counter: counts data steps, then restarts to count tail steps
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (start) begin
            step_cnt <= '0;
        end else if (step_en) begin
            if (data_last || last_tail) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + CW'(1);
            end
        end
    end

    // Hold beat A lanes until beat B completes the step
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cap <= 1'b0;
            z_cap <= 1'b0;
        end else if (capture) begin
            x_cap <= in0;
            z_cap <= in1;
        end
    end

    // Registered data outputs, strobed once per data step
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out      <= 1'b0;
            z_out      <= 1'b0;
            zp_out     <= 1'b0;
            data_valid <= 1'b0;
        end else if (data_step) begin
            x_out      <= x_cap;
            z_out      <= z_cap;
            zp_out     <= in0;
            data_valid <= 1'b1;
        end else begin
            data_valid <= 1'b0;
        end
    end

    // Per-block error status: cleared on the first beat, saturating count
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= '0;
            parity_err <= 1'b0;
        end else if (start) begin
            err_count  <= '0;
            parity_err <= 1'b0;
        end else if (err_inc != 2'd0) begin
            err_count  <= err_sum[ERRW] ? '1 : err_sum[ERRW-1:0];
            parity_err <= 1'b1;
        end
    end

    assign block_done = (state == DONE);
    assign busy       = (state != IDLE);

endmodule
